// File: rtl/vid2is_regs_pkg.sv
// Register map, bit positions and read-handshake state type shared by the
// clocked-video input control slave.
package vid2is_regs_pkg;

    localparam logic [7:0] ADDR_CONTROL   = 8'd0;
    localparam logic [7:0] ADDR_STATUS    = 8'd1;
    localparam logic [7:0] ADDR_INTERRUPT = 8'd2;
    localparam logic [7:0] ADDR_USEDW     = 8'd3;
    localparam logic [7:0] ADDR_WIDTH     = 8'd4;
    localparam logic [7:0] ADDR_F0_LINES  = 8'd5;
    localparam logic [7:0] ADDR_F1_LINES  = 8'd6;

    localparam int CTRL_GO        = 0;
    localparam int CTRL_IE_RES    = 1;
    localparam int CTRL_IE_STABLE = 2;

    localparam int STS_RUNNING    = 0;
    localparam int STS_INTERLACED = 1;
    localparam int STS_STABLE     = 2;
    localparam int STS_OVERFLOW   = 3;

    localparam int INT_RES        = 1;
    localparam int INT_STABLE     = 2;

    // RD_DATA is the cycle in which av_readdata is presented (rd_pend = 1).
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/vid2is_res_tracker.sv
// Holds the last detected resolution per field and flags a change whenever a
// field report differs from what is stored.
module vid2is_res_tracker #(
    parameter int DIM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 res_valid,
    input  logic [DIM_WIDTH-1:0] res_width,
    input  logic [DIM_WIDTH-1:0] res_height,
    input  logic                 res_field,
    output logic [DIM_WIDTH-1:0] width_r,
    output logic [DIM_WIDTH-1:0] f0_lines,
    output logic [DIM_WIDTH-1:0] f1_lines,
    output logic                 res_change
);

    logic [DIM_WIDTH-1:0] cur_lines;

    always_comb begin
        cur_lines  = res_field ? f1_lines : f0_lines;
        res_change = res_valid && ((res_width != width_r) || (res_height != cur_lines));
    end

    // Width is shared by both fields; line count is kept per field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_r  <= '0;
            f0_lines <= '0;
            f1_lines <= '0;
        end else if (res_change) begin
            width_r <= res_width;
            if (res_field) begin
                f1_lines <= res_height;
            end else begin
                f0_lines <= res_height;
            end
        end
    end

endmodule

// File: rtl/vid2is_control.sv
// Avalon-MM control/status slave for the video-to-ImageStream input path:
// frame-aligned go/running gating, resolution capture, overflow sticky, IRQ.
module vid2is_control
    import vid2is_regs_pkg::*;
#(
    parameter int USED_WORDS_WIDTH = 15,
    parameter int DIM_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sof,
    input  logic                        res_valid,
    input  logic [DIM_WIDTH-1:0]        res_width,
    input  logic [DIM_WIDTH-1:0]        res_height,
    input  logic                        res_field,
    input  logic                        interlaced,
    input  logic                        stable,
    input  logic                        overflow,
    input  logic [USED_WORDS_WIDTH-1:0] usedw,
    output logic                        enable,
    output logic                        status_update_int,
    input  logic [7:0]                  av_address,
    input  logic                        av_read,
    output logic [15:0]                 av_readdata,
    input  logic                        av_write,
    input  logic [15:0]                 av_writedata,
    output logic                        av_waitrequest
);

    logic go, ie_res, ie_stable, running;
    logic overflow_sticky, int_res, int_stable, stable_d;
    logic wr_ctrl, wr_sts, wr_int;
    logic res_change;
    logic [DIM_WIDTH-1:0] width_r, f0_lines, f1_lines;
    logic [15:0] rd_data;
    rd_state_t rd_state, rd_state_next;
    logic rd_pend, rd_capture;
    logic unused_ok;

    assign unused_ok = ^av_writedata[15:4];

    vid2is_res_tracker #(.DIM_WIDTH(DIM_WIDTH)) u_res_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (res_valid),
        .res_width  (res_width),
        .res_height (res_height),
        .res_field  (res_field),
        .width_r    (width_r),
        .f0_lines   (f0_lines),
        .f1_lines   (f1_lines),
        .res_change (res_change)
    );

    always_comb begin
        wr_ctrl = av_write && (av_address == ADDR_CONTROL);
        wr_sts  = av_write && (av_address == ADDR_STATUS);
        wr_int  = av_write && (av_address == ADDR_INTERRUPT);
    end

    // running only moves on sof, so a frame is never cut or started mid-way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go              <= 1'b0;
            ie_res          <= 1'b0;
            ie_stable       <= 1'b0;
            running         <= 1'b0;
            overflow_sticky <= 1'b0;
            int_res         <= 1'b0;
            int_stable      <= 1'b0;
            stable_d        <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                go        <= av_writedata[CTRL_GO];
                ie_res    <= av_writedata[CTRL_IE_RES];
                ie_stable <= av_writedata[CTRL_IE_STABLE];
            end
            if (sof) begin
                running <= go;
            end
            stable_d        <= stable;
            overflow_sticky <= overflow | (overflow_sticky & ~(wr_sts & av_writedata[STS_OVERFLOW]));
            int_res    <= ie_res & (res_change |
                          (int_res & ~(wr_int & av_writedata[INT_RES])));
            int_stable <= ie_stable & ((stable != stable_d) |
                          (int_stable & ~(wr_int & av_writedata[INT_STABLE])));
        end
    end

    assign enable            = running;
    assign status_update_int = int_res | int_stable;

    always_comb begin
        rd_data = '0;
        case (av_address)
            ADDR_CONTROL: begin
                rd_data[CTRL_GO]        = go;
                rd_data[CTRL_IE_RES]    = ie_res;
                rd_data[CTRL_IE_STABLE] = ie_stable;
            end
            ADDR_STATUS: begin
                rd_data[STS_RUNNING]    = running;
                rd_data[STS_INTERLACED] = interlaced;
                rd_data[STS_STABLE]     = stable;
                rd_data[STS_OVERFLOW]   = overflow_sticky;
            end
            ADDR_INTERRUPT: begin
                rd_data[INT_RES]    = int_res;
                rd_data[INT_STABLE] = int_stable;
            end
            ADDR_USEDW:    rd_data = 16'(usedw);
            ADDR_WIDTH:    rd_data = 16'(width_r);
            ADDR_F0_LINES: rd_data = 16'(f0_lines);
            ADDR_F1_LINES: rd_data = 16'(f1_lines);
            default:       rd_data = '0;
        endcase
    end

    // Read handshake: the master holds av_read until it sees av_waitrequest low;
    // the first cycle stalls and captures, the second presents av_readdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_state_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state;
        rd_capture    = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (av_read) begin
                    rd_capture    = 1'b1;
                    rd_state_next = RD_DATA;
                end
            end
            RD_DATA: rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    assign rd_pend        = (rd_state == RD_DATA);
    assign av_waitrequest = rst_n & rd_capture & ~rd_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            av_readdata <= '0;
        end else if (rd_capture) begin
            av_readdata <= rd_data;
        end
    end

endmodule

// File: tb/tb_vid2is_control.sv
// Directed and randomized bench for vid2is_control, compared against a
// behavioural register-level model of the control slave.
module tb_vid2is_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof, res_valid, res_field, interlaced, stable, overflow;
    logic [15:0] res_width, res_height;
    logic [14:0] usedw;
    logic        enable, status_update_int;
    logic [7:0]  av_address;
    logic        av_read, av_write, av_waitrequest;
    logic [15:0] av_readdata, av_writedata;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic        m_go, m_ie_res, m_ie_stable, m_running;
    logic        m_sticky, m_int_res, m_int_stable, m_stable_prev;
    logic [15:0] m_width;
    logic [15:0] m_lines[2];

    vid2is_control dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .sof               (sof),
        .res_valid         (res_valid),
        .res_width         (res_width),
        .res_height        (res_height),
        .res_field         (res_field),
        .interlaced        (interlaced),
        .stable            (stable),
        .overflow          (overflow),
        .usedw             (usedw),
        .enable            (enable),
        .status_update_int (status_update_int),
        .av_address        (av_address),
        .av_read           (av_read),
        .av_readdata       (av_readdata),
        .av_write          (av_write),
        .av_writedata      (av_writedata),
        .av_waitrequest    (av_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_go = 0; m_ie_res = 0; m_ie_stable = 0; m_running = 0;
        m_sticky = 0; m_int_res = 0; m_int_stable = 0; m_stable_prev = 0;
        m_width = 0; m_lines[0] = 0; m_lines[1] = 0;
    endtask

    // Applies one clock edge worth of register rules to the model.
    task automatic model_step();
        logic old_go, old_ie_res, old_ie_stable, res_evt, st_evt;
        old_go = m_go; old_ie_res = m_ie_res; old_ie_stable = m_ie_stable;
        res_evt = 0;
        if (res_valid && (res_width != m_width || res_height != m_lines[res_field])) begin
            res_evt = 1;
            m_width = res_width;
            m_lines[res_field] = res_height;
        end
        st_evt = (stable != m_stable_prev);
        m_stable_prev = stable;
        if (sof) m_running = old_go;
        if (av_write && av_address == 8'd0) begin
            m_go = av_writedata[0]; m_ie_res = av_writedata[1]; m_ie_stable = av_writedata[2];
        end
        if (!old_ie_res) m_int_res = 0;
        else if (res_evt) m_int_res = 1;
        else if (av_write && av_address == 8'd2 && av_writedata[1]) m_int_res = 0;
        if (!old_ie_stable) m_int_stable = 0;
        else if (st_evt) m_int_stable = 1;
        else if (av_write && av_address == 8'd2 && av_writedata[2]) m_int_stable = 0;
        if (overflow) m_sticky = 1;
        else if (av_write && av_address == 8'd1 && av_writedata[3]) m_sticky = 0;
    endtask

    function automatic logic [15:0] model_read(input logic [7:0] a);
        case (a)
            8'd0: return {13'b0, m_ie_stable, m_ie_res, m_go};
            8'd1: return {12'b0, m_sticky, stable, interlaced, m_running};
            8'd2: return {13'b0, m_int_stable, m_int_res, 1'b0};
            8'd3: return {1'b0, usedw};
            8'd4: return m_width;
            8'd5: return m_lines[0];
            8'd6: return m_lines[1];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        sof = 0; res_valid = 0; overflow = 0; av_write = 0;
        check("enable", 16'(enable), 16'(m_running));
        check("irq", 16'(status_update_int), 16'(m_int_res | m_int_stable));
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        av_address = a; av_writedata = d; av_write = 1;
        #1 check("wr_waitreq", 16'(av_waitrequest), 16'h0);
        tick();
    endtask

    task automatic do_read(input logic [7:0] a, output logic [15:0] d);
        logic [15:0] e;
        av_address = a; av_read = 1;
        #1 check("rd_waitreq_hi", 16'(av_waitrequest), 16'h1);
        e = model_read(a);
        tick();
        check("rd_waitreq_lo", 16'(av_waitrequest), 16'h0);
        check($sformatf("rd_addr%0d", a), av_readdata, e);
        d = av_readdata;
        tick();
        av_read = 0;
    endtask

    initial begin
        logic [15:0] d;
        int op;
        rst_n = 0; sof = 0; res_valid = 0; res_field = 0; interlaced = 0; stable = 0;
        overflow = 0; res_width = 0; res_height = 0; usedw = 0;
        av_address = 0; av_read = 0; av_write = 0; av_writedata = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_enable", 16'(enable), 16'h0);
        check("rst_irq", 16'(status_update_int), 16'h0);
        check("rst_readdata", av_readdata, 16'h0);
        check("rst_waitreq", 16'(av_waitrequest), 16'h0);
        rst_n = 1;

        for (int a = 0; a < 8; a++) begin
            do_read(8'(a), d);
            check("rst_reg_zero", d, 16'h0000);
        end

        // go set mid-frame waits for sof; cleared go lets the frame finish
        do_write(8'd0, 16'h0001);
        tick(); tick();
        check("go_wait_sof", 16'(enable), 16'h0);
        sof = 1; tick();
        check("go_running", 16'(enable), 16'h1);
        do_write(8'd0, 16'h0000);
        tick();
        check("stop_hold", 16'(enable), 16'h1);
        sof = 1; tick();
        check("stop_at_sof", 16'(enable), 16'h0);
        sof = 1; do_write(8'd0, 16'h0001);
        check("sof_old_go", 16'(enable), 16'h0);
        sof = 1; tick();
        check("sof_new_go", 16'(enable), 16'h1);

        // Resolution change interrupt
        do_write(8'd0, 16'h0003);
        res_valid = 1; res_width = 16'd1920; res_height = 16'd540; res_field = 0;
        tick();
        check("res_irq", 16'(status_update_int), 16'h1);
        do_read(8'd4, d); check("width_1920", d, 16'h0780);
        do_read(8'd5, d); check("f0_540", d, 16'h021C);
        do_write(8'd2, 16'h0002);
        check("res_irq_clr", 16'(status_update_int), 16'h0);
        res_valid = 1; tick();
        check("same_res_no_irq", 16'(status_update_int), 16'h0);

        // Set beats same-cycle clear for int_res and overflow sticky
        res_valid = 1; res_width = 16'd1280; res_height = 16'd720; res_field = 0;
        do_write(8'd2, 16'h0002);
        check("set_wins_irq", 16'(status_update_int), 16'h1);
        do_read(8'd2, d); check("int_res_bit", d, 16'h0002);
        overflow = 1; do_write(8'd1, 16'h0008);
        do_read(8'd1, d); check("ovf_set_wins", 16'(d[3]), 16'h1);
        do_write(8'd1, 16'h0008);
        do_read(8'd1, d); check("ovf_cleared", 16'(d[3]), 16'h0);

        // Stability interrupt
        do_write(8'd2, 16'h0002);
        stable = 1; tick(); tick();
        check("stable_masked", 16'(status_update_int), 16'h0);
        do_write(8'd0, 16'h0007);
        stable = 0; tick();
        check("stable_irq", 16'(status_update_int), 16'h1);
        do_read(8'd2, d); check("int_stable_reg", d, 16'h0004);
        do_read(8'd1, d); check("sts_stable_0", 16'(d[2]), 16'h0);

        // Async reset during a read's wait cycle
        av_address = 8'd4; av_read = 1;
        #1 check("pre_rst_waitreq", 16'(av_waitrequest), 16'h1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_enable", 16'(enable), 16'h0);
        check("mid_rst_irq", 16'(status_update_int), 16'h0);
        check("mid_rst_readdata", av_readdata, 16'h0);
        check("mid_rst_waitreq", 16'(av_waitrequest), 16'h0);
        model_reset();
        @(negedge clk); av_read = 0;
        @(negedge clk); rst_n = 1;
        do_read(8'd4, d); check("post_rst_read", d, 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            interlaced = 1'($urandom_range(0, 1));
            usedw = 15'($urandom);
            if ($urandom_range(0, 11) == 0) stable = ~stable;
            sof = ($urandom_range(0, 7) == 0);
            overflow = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) begin
                res_valid = 1;
                res_width = $urandom_range(0, 1) ? 16'd1920 : 16'd1280;
                res_height = $urandom_range(0, 1) ? 16'd540 : 16'd720;
                res_field = 1'($urandom_range(0, 1));
            end
            op = $urandom_range(0, 9);
            case (op)
                0, 1: do_read(8'($urandom_range(0, 7)), d);
                2: do_write(8'd0, 16'($urandom));
                3: do_write(8'd1, 16'($urandom));
                4: do_write(8'd2, 16'($urandom));
                5: do_write(8'($urandom_range(3, 255)), 16'($urandom));
                default: tick();
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vid2is_control.md
Name: vid2is_control

Overview:
- Avalon-MM control/status slave for the clocked-video *input* path (video-to-ImageStream), the receive-side counterpart of the video-output control block.
- Gates the input stream on frame boundaries via a go/running handshake.
- Captures detected resolution per field, maintains an overflow sticky, and raises a level interrupt on resolution-change or stability-change events.

Parameters:
- USED_WORDS_WIDTH, 15, width of input FIFO fill level; zero-extended or truncated to 16 bits on readback.
- DIM_WIDTH, 16, width of detected sample/line counts (1..16); zero-extended to 16 bits on readback.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sof  in  1  single-cycle pulse at each input field/frame boundary
- res_valid  in  1  single-cycle pulse: res_width/res_height/res_field describe the field just ended
- res_width  in  DIM_WIDTH  active samples per line
- res_height  in  DIM_WIDTH  active lines in field
- res_field  in  1  0 = F0, 1 = F1
- interlaced  in  1  detector interlace flag (level)
- stable  in  1  detector resolution-stable flag (level)
- overflow  in  1  single-cycle FIFO overflow pulse
- usedw  in  USED_WORDS_WIDTH  FIFO fill level
- enable  out  1  registered "running"; front end writes to FIFO only when high
- status_update_int  out  1  interrupt request, level
- av_address  in  8  word address
- av_read  in  1  read strobe
- av_readdata  out  16  read data, registered
- av_write  in  1  write strobe
- av_writedata  in  16  write data
- av_waitrequest  out  1  stall

Behaviour:
- Reset (rst_n low, async): all outputs and registers 0.
  - Covers go, running/enable, ie[1:0], overflow_sticky, int_res, int_stable, stable_d, width_r, f0_lines, f1_lines, av_readdata, rd_pend.
- Register map, addresses as decimal words:
  - 0 CONTROL RW: bit0 go; bit1 ie_res; bit2 ie_stable.
  - 1 STATUS: bit0 running (RO); bit1 interlaced (RO); bit2 stable (RO); bit3 overflow_sticky (W1C); others 0.
  - 2 INTERRUPT W1C: bit1 int_res; bit2 int_stable.
  - 3 usedw, RO, zero-extended.
  - 4 width_r, RO.
  - 5 f0_lines, RO.
  - 6 f1_lines, RO.
  - Unmapped addresses read 0; writes to them are ignored.
- Writes:
  - Zero wait states; av_waitrequest never asserted for a write.
  - Take effect at the clock edge where av_write is high.
- Reads: two-state handshake (IDLE, DATA).
  - Cycle N: av_read high and rd_pend = 0 -> av_waitrequest = 1 (combinational). Readdata is captured at the end of this cycle and rd_pend is set.
  - Cycle N+1: av_waitrequest = 0 and av_readdata is valid. rd_pend clears.
  - Back-to-back reads therefore complete every 2 cycles.
  - av_read and av_write are never asserted together (master guarantee); behaviour in that case is don't-care.
- Go/running:
  - running changes only on a sof pulse: running <= go.
  - Clearing go mid-frame keeps enable high until the next sof, so the current frame completes.
  - Setting go mid-frame starts output at the next sof, never mid-frame.
  - Same-cycle write of go and sof: the sof samples the *old* go.
- Resolution capture, on res_valid:
  - res_field = 0: compare res_width/res_height against width_r/f0_lines.
  - res_field = 1: compare res_width/res_height against width_r/f1_lines.
  - Any difference -> load the new values and set int_res if ie_res = 1.
  - Identical values -> no register or interrupt change.
- Stability: stable_d <= stable every cycle. stable != stable_d sets int_stable if ie_stable = 1.
- Interrupt bits:
  - Set has priority over a same-cycle W1C clear.
  - Each bit is forced to 0 while its enable is 0.
  - status_update_int = int_res | int_stable, registered sources only.
- Overflow sticky:
  - overflow pulse sets it.
  - Writing 1 to address 1 bit3 clears it.
  - Set wins on same-cycle set and clear.
  - It does not gate enable.
- Reset mid-read: rd_pend and av_readdata return to 0. The master sees av_waitrequest = 0 with readdata 0.

Decomposition:
- Shared package, vid2is_regs_pkg:
  - address constants ADDR_CONTROL=0, ADDR_STATUS=1, ADDR_INTERRUPT=2, ADDR_USEDW=3, ADDR_WIDTH=4, ADDR_F0_LINES=5, ADDR_F1_LINES=6.
  - bit-index constants CTRL_GO=0, CTRL_IE_RES=1, CTRL_IE_STABLE=2, STS_RUNNING=0, STS_INTERLACED=1, STS_STABLE=2, STS_OVERFLOW=3, INT_RES=1, INT_STABLE=2.
- One natural sub-module, vid2is_res_tracker: res_valid compare/capture logic and the int_res set pulse.
- Register file, read handshake and go/running logic stay in the top module.

Test Plan:
- Reset then read addr 0..7 -> each read takes 2 cycles (av_waitrequest high 1 cycle); all return 0x0000.
- Go/running: write addr0 = 0x0001 mid-frame -> enable stays 0 until next sof, then 1. Write 0x0000 -> enable stays 1 until following sof, then 0.
- Resolution change: write addr0 = 0x0003, pulse res_valid with width 1920, height 540, field 0 -> addr4 = 0x0780, addr5 = 0x021C, status_update_int = 1. Repeat identical values after a W1C of addr2 = 0x0002 -> interrupt stays 0.
- Simultaneous set/clear: W1C addr2 bit1 in the same cycle as a changing res_valid -> int_res remains 1. Overflow pulse with same-cycle addr1 write 0x0008 -> sticky = 1.
- Stability interrupt: ie_stable = 0, toggle stable -> no interrupt. Set ie_stable = 1, toggle stable 1->0 -> addr2 reads 0x0004, addr1 bit2 = 0.
- Async reset asserted during a read's wait cycle -> all outputs 0 immediately; first read after release completes normally.
